// File: rtl/pci_target_mem.sv
// -----------------------------------------------------------------------------
// pci_target_mem
//
// Minimal PCI memory target backed by an 8 x 32-bit register file. It decodes
// a 32-byte window at BASE_ADDR, accepts memory-read and memory-write commands,
// supports linear bursts (the word index wraps 7 -> 0) and inserts WAIT_STATES
// target wait cycles before the first data phase only.
//
// Ports
//   clk        bus clock, every input sampled on the rising edge
//   rst        asynchronous, active-high reset (also clears the memory)
//   AD         multiplexed address/data bus; driven by this block only while
//              a read is in its WAIT or DATA state
//   C_BE       command during the address phase, active-low byte enables
//              during data phases
//   FRAME      active-low master framing
//   IRDY       active-low master ready
//   DEVSEL     active-low device select, driven 0/1 during a claimed
//              transaction and Z otherwise
//   TRDY       active-low target ready, driven 0/1 during a claimed
//              transaction and Z otherwise
//   xfer_done  one-cycle pulse in the cycle after each completed data phase
//   xfer_count number of completed data phases since reset (wraps 255 -> 0)
//
// Handshake: a data phase completes on a rising edge where IRDY=0 and TRDY=0.
// TRDY is only ever low in DATA, so "completion" is DATA && !IRDY. A
// completion with FRAME=1 is the last phase of the burst. FRAME=1 with IRDY=1
// in WAIT or DATA means the master has given up and the target backs off
// without transferring anything.
// -----------------------------------------------------------------------------
module pci_target_mem #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0100,
    parameter int unsigned WAIT_STATES = 1,
    parameter logic [3:0]  READ_CMD    = 4'b0110,
    parameter logic [3:0]  WRITE_CMD   = 4'b0111
) (
    input  logic        clk,
    input  logic        rst,
    inout  wire  [31:0] AD,
    input  logic [3:0]  C_BE,
    input  logic        FRAME,
    input  logic        IRDY,
    inout  wire         DEVSEL,
    inout  wire         TRDY,
    output logic        xfer_done,
    output logic [7:0]  xfer_count
);

    localparam logic [2:0] WAIT_CNT_INIT = 3'(WAIT_STATES);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        WAIT   = 3'd2,
        DATA   = 3'd3,
        TURN   = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;

    logic        prev_frame;
    logic [2:0]  idx;
    logic        cmd_is_read;
    logic [2:0]  wait_cnt;
    logic [31:0] mem [0:7];

    // Tri-state controls produced by the output process.
    logic        devsel_oe;
    logic        devsel_val;
    logic        trdy_oe;
    logic        trdy_val;
    logic        ad_oe;

    // -------------------------------------------------------------------------
    // Event decode
    // -------------------------------------------------------------------------
    logic addr_phase;
    logic addr_hit;
    logic take_addr;
    logic xfer_ok;
    logic abandon;

    // Address phase = falling edge of FRAME as seen by two consecutive samples.
    // Only IDLE looks at it, so a master re-arbitrating during TURN is ignored
    // and, because FRAME is then already low when IDLE is reached, stays ignored.
    assign addr_phase = (state == IDLE) && !FRAME && prev_frame;
    assign addr_hit   = (AD[31:5] == BASE_ADDR[31:5]) &&
                        ((C_BE == READ_CMD) || (C_BE == WRITE_CMD));
    assign take_addr  = addr_phase && addr_hit;

    assign xfer_ok    = (state == DATA) && !IRDY;
    assign abandon    = ((state == WAIT) || (state == DATA)) && FRAME && IRDY;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (take_addr) begin
                    state_next = DECODE;
                end
            end
            DECODE: begin
                if (WAIT_STATES != 0) begin
                    state_next = WAIT;
                end else begin
                    state_next = DATA;
                end
            end
            WAIT: begin
                // The counter holds the waits still to serve including this
                // cycle, so a value of 1 means this is the last one.
                if (abandon) begin
                    state_next = TURN;
                end else if (wait_cnt <= 3'd1) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                // After the first data phase TRDY stays low: the only exits
                // are the last completion and a master abandon.
                if (xfer_ok && FRAME) begin
                    state_next = TURN;
                end else if (abandon) begin
                    state_next = TURN;
                end
            end
            TURN: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs
    // -------------------------------------------------------------------------
    always_comb begin
        devsel_oe  = 1'b0;
        devsel_val = 1'b1;
        trdy_oe    = 1'b0;
        trdy_val   = 1'b1;
        ad_oe      = 1'b0;
        case (state)
            DECODE: begin
                // AD is still in its turnaround cycle here, so it stays released.
                devsel_oe  = 1'b1;
                devsel_val = 1'b0;
                trdy_oe    = 1'b1;
            end
            WAIT: begin
                devsel_oe  = 1'b1;
                devsel_val = 1'b0;
                trdy_oe    = 1'b1;
                ad_oe      = cmd_is_read;
            end
            DATA: begin
                devsel_oe  = 1'b1;
                devsel_val = 1'b0;
                trdy_oe    = 1'b1;
                trdy_val   = 1'b0;
                ad_oe      = cmd_is_read;
            end
            TURN: begin
                // Actively drive the strobes high for one cycle before
                // releasing them, so the pull-ups do not have to do the work.
                devsel_oe  = 1'b1;
                trdy_oe    = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign DEVSEL = devsel_oe ? devsel_val : 1'bz;
    assign TRDY   = trdy_oe ? trdy_val : 1'bz;
    // Read data follows idx combinationally, so the word after a completion
    // appears on AD in the very next cycle.
    assign AD     = ad_oe ? mem[idx] : 32'hzzzz_zzzz;

    // -------------------------------------------------------------------------
    // Datapath: address latch, wait counter, memory, transfer accounting
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_frame  <= 1'b1;
            idx         <= 3'd0;
            cmd_is_read <= 1'b0;
            wait_cnt    <= 3'd0;
            xfer_done   <= 1'b0;
            xfer_count  <= 8'd0;
            for (int i = 0; i < 8; i++) begin
                mem[i] <= 32'd0;
            end
        end else begin
            prev_frame <= FRAME;
            xfer_done  <= xfer_ok;

            if (take_addr) begin
                idx         <= AD[4:2];
                cmd_is_read <= (C_BE == READ_CMD);
            end

            case (state)
                DECODE: begin
                    wait_cnt <= WAIT_CNT_INIT;
                end
                WAIT: begin
                    if (wait_cnt != 3'd0) begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                default: begin
                end
            endcase

            if (xfer_ok) begin
                if (!cmd_is_read) begin
                    for (int b = 0; b < 4; b++) begin
                        if (!C_BE[b]) begin
                            mem[idx][8*b +: 8] <= AD[8*b +: 8];
                        end
                    end
                end
                idx        <= idx + 3'd1;
                xfer_count <= xfer_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pci_target_mem.sv
// -----------------------------------------------------------------------------
// tb_pci_target_mem
//
// Directed PCI master stimulus against pci_target_mem with the default
// parameters. A transaction-level reference model tracks each claimed
// transaction by its age in cycles since the address phase and predicts
// DEVSEL, TRDY, AD (while the master has released it), xfer_done and
// xfer_count; a single compare process checks those every falling edge.
// Literal expectations taken directly from the block's behaviour pin the model.
// DEVSEL/TRDY carry pull-ups and AD a pull-down, so a released line reads as
// 1 (strobes) or 0 (AD).
// -----------------------------------------------------------------------------
module tb_pci_target_mem;

    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam int          WS   = 1;
    localparam logic [3:0]  RD   = 4'b0110;
    localparam logic [3:0]  WR   = 4'b0111;

    // ---------------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [3:0]  cbe     = 4'hf;
    logic        frame   = 1'b1;
    logic        irdy    = 1'b1;
    logic [31:0] m_ad    = 32'd0;
    logic        m_ad_oe = 1'b0;

    wire  [31:0] ad;
    wire         devsel;
    wire         trdy;
    logic        xfer_done;
    logic [7:0]  xfer_count;

    assign ad = m_ad_oe ? m_ad : 32'hzzzz_zzzz;
    pulldown (ad);
    pullup (devsel);
    pullup (trdy);

    pci_target_mem dut (
        .clk        (clk),
        .rst        (rst),
        .AD         (ad),
        .C_BE       (cbe),
        .FRAME      (frame),
        .IRDY       (irdy),
        .DEVSEL     (devsel),
        .TRDY       (trdy),
        .xfer_done  (xfer_done),
        .xfer_count (xfer_count)
    );

    // ---------------------------------------------------------------- scoreboard
    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    // A claimed transaction is described by its age: age 1 is the first cycle
    // after the address phase (DEVSEL asserts), data phases are possible from
    // age WS+2 on, and the target drives read data from age 2 on.
    logic [31:0] mdl_mem [8];
    logic        mdl_active;
    logic        mdl_turn;
    logic        mdl_read;
    logic        mdl_done;
    logic        mdl_prev_frame;
    int          mdl_age;
    logic [2:0]  mdl_idx;
    logic [7:0]  mdl_count;

    wire mdl_data_ph = mdl_active && (mdl_age >= WS + 2);
    wire mdl_drives  = mdl_active && mdl_read && (mdl_age >= 2);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mdl_active     <= 1'b0;
            mdl_turn       <= 1'b0;
            mdl_read       <= 1'b0;
            mdl_done       <= 1'b0;
            mdl_prev_frame <= 1'b1;
            mdl_age        <= 0;
            mdl_idx        <= 3'd0;
            mdl_count      <= 8'd0;
            for (int i = 0; i < 8; i++) mdl_mem[i] <= 32'd0;
        end else begin
            mdl_prev_frame <= frame;
            mdl_done       <= 1'b0;
            if (mdl_turn) begin
                mdl_turn <= 1'b0;
            end else if (!mdl_active) begin
                if (!frame && mdl_prev_frame && (m_ad[31:5] == BASE[31:5]) &&
                    ((cbe == RD) || (cbe == WR))) begin
                    mdl_active <= 1'b1;
                    mdl_age    <= 1;
                    mdl_idx    <= m_ad[4:2];
                    mdl_read   <= (cbe == RD);
                end
            end else begin
                mdl_age <= mdl_age + 1;
                if (mdl_data_ph && !irdy) begin
                    if (!mdl_read) begin
                        for (int b = 0; b < 4; b++)
                            if (!cbe[b]) mdl_mem[mdl_idx][8*b +: 8] <= m_ad[8*b +: 8];
                    end
                    mdl_idx   <= mdl_idx + 3'd1;
                    mdl_count <= mdl_count + 8'd1;
                    mdl_done  <= 1'b1;
                    if (frame) begin
                        mdl_active <= 1'b0;
                        mdl_turn   <= 1'b1;
                    end
                end else if ((mdl_age >= 2) && frame && irdy) begin
                    mdl_active <= 1'b0;
                    mdl_turn   <= 1'b1;
                end
            end
        end
    end

    // ---------------------------------------------------------------- compare
    always @(negedge clk) begin
        if (!rst) begin
            check("devsel", {31'd0, devsel}, {31'd0, !mdl_active});
            check("trdy", {31'd0, trdy}, {31'd0, !mdl_data_ph});
            if (!m_ad_oe) check("ad", ad, mdl_drives ? mdl_mem[mdl_idx] : 32'd0);
            check("xfer_done", {31'd0, xfer_done}, {31'd0, mdl_done});
            check("xfer_count", {24'd0, xfer_count}, {24'd0, mdl_count});
        end
    end

    // ---------------------------------------------------------------- driver
    logic [31:0] wr_buf [8];
    logic [3:0]  be_buf [8];
    logic [31:0] rd_buf [8];
    int          first_lat;
    logic        first_devsel;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic release_bus();
        frame   = 1'b1;
        irdy    = 1'b1;
        cbe     = 4'hf;
        m_ad_oe = 1'b0;
    endtask

    task automatic idle(input int n);
        release_bus();
        repeat (n) step();
    endtask

    // Runs one burst of n data phases. Entered and left at posedge+2. With
    // rst_after > 0 the block is reset right after that many completions.
    task automatic burst(input logic [31:0] addr, input logic [3:0] cmd,
                         input int n, input int rst_after);
        logic got;
        frame   = 1'b0;
        irdy    = 1'b1;
        cbe     = cmd;
        m_ad    = addr;
        m_ad_oe = 1'b1;
        step();
        first_lat = -1;
        for (int k = 0; k < n; k++) begin
            frame   = (k == n - 1);
            irdy    = 1'b0;
            cbe     = (cmd == WR) ? be_buf[k] : 4'h0;
            m_ad    = wr_buf[k];
            m_ad_oe = (cmd == WR);
            got     = 1'b0;
            for (int c = 0; c < 20 && !got; c++) begin
                @(negedge clk);
                if (k == 0 && c == 0) first_devsel = devsel;
                got = (trdy === 1'b0);
                if (got) begin
                    rd_buf[k] = ad;
                    if (k == 0) first_lat = c;
                end
                step();
            end
            if (!got) begin
                check("trdy_timeout", 32'd0, 32'd1);
                release_bus();
                return;
            end
            if (rst_after > 0 && k + 1 == rst_after) begin
                rst = 1'b1;
                #1;
                check("rst_devsel_z", {31'd0, devsel}, 32'd1);
                check("rst_trdy_z", {31'd0, trdy}, 32'd1);
                check("rst_count", {24'd0, xfer_count}, 32'd0);
                check("rst_done", {31'd0, xfer_done}, 32'd0);
                release_bus();
                step();
                rst = 1'b0;
                return;
            end
        end
        release_bus();
    endtask

    // ---------------------------------------------------------------- sequence
    initial begin
        #1;
        check("reset_count", {24'd0, xfer_count}, 32'd0);
        check("reset_devsel", {31'd0, devsel}, 32'd1);
        check("reset_trdy", {31'd0, trdy}, 32'd1);
        repeat (3) step();
        rst = 1'b0;
        idle(2);

        // Single write of 0xDEADBEEF to word 1.
        wr_buf[0] = 32'hDEAD_BEEF; be_buf[0] = 4'h0;
        burst(32'h0000_0104, WR, 1, 0);
        check("wr1_devsel_first", {31'd0, first_devsel}, 32'd0);
        check("wr1_trdy_lat", first_lat, 32'd2);
        check("wr1_count", {24'd0, xfer_count}, 32'd1);
        idle(2);

        // Read it back.
        burst(32'h0000_0104, RD, 1, 0);
        check("rd1_data", rd_buf[0], 32'hDEAD_BEEF);
        check("rd1_count", {24'd0, xfer_count}, 32'd2);
        idle(2);

        // Three-word burst write starting at word 7 wraps to words 0 and 1.
        wr_buf[0] = 32'hA1A1_0007; wr_buf[1] = 32'hA2A2_0000; wr_buf[2] = 32'hA3A3_0001;
        be_buf[0] = 4'h0; be_buf[1] = 4'h0; be_buf[2] = 4'h0;
        burst(32'h0000_011C, WR, 3, 0);
        check("bw_count", {24'd0, xfer_count}, 32'd5);
        idle(2);
        burst(32'h0000_0100, RD, 8, 0);
        check("bw_mem7", rd_buf[7], 32'hA1A1_0007);
        check("bw_mem0", rd_buf[0], 32'hA2A2_0000);
        check("bw_mem1", rd_buf[1], 32'hA3A3_0001);
        check("bw_mem2", rd_buf[2], 32'h0000_0000);
        check("bw_rd_count", {24'd0, xfer_count}, 32'd13);
        idle(2);

        // Byte enables 1010: only bytes 0 and 2 land.
        wr_buf[0] = 32'h1122_3344; be_buf[0] = 4'b1010;
        burst(32'h0000_0108, WR, 1, 0);
        idle(1);
        burst(32'h0000_0108, RD, 1, 0);
        check("be_data", rd_buf[0], 32'h0022_0044);
        idle(2);

        // Miss by address, then miss by command: no response, no count.
        frame = 1'b0; cbe = WR; m_ad = 32'h0000_0200; m_ad_oe = 1'b1;
        step();
        idle(4);
        frame = 1'b0; cbe = 4'b0010; m_ad = 32'h0000_0104; m_ad_oe = 1'b1;
        step();
        idle(4);
        check("miss_count", {24'd0, xfer_count}, 32'd15);

        // Master abandons right after the address phase.
        frame = 1'b0; cbe = WR; m_ad = 32'h0000_0104; m_ad_oe = 1'b1;
        step();
        idle(5);
        check("abandon_count", {24'd0, xfer_count}, 32'd15);

        // Write, then a new address phase already during TURN is ignored.
        wr_buf[0] = 32'h0BAD_F00D; be_buf[0] = 4'h0;
        burst(32'h0000_0110, WR, 1, 0);
        frame = 1'b0; cbe = WR; m_ad = 32'h0000_0100; m_ad_oe = 1'b1;
        step();
        step();
        idle(4);
        check("b2b_count", {24'd0, xfer_count}, 32'd16);

        // Reset after the first of four burst words.
        for (int i = 0; i < 4; i++) begin
            wr_buf[i] = 32'h7700_0000 + i; be_buf[i] = 4'h0;
        end
        burst(32'h0000_0100, WR, 4, 1);
        idle(2);
        burst(32'h0000_0100, RD, 8, 0);
        for (int i = 0; i < 8; i++) check("post_rst_mem", rd_buf[i], 32'd0);
        idle(1);
        wr_buf[0] = 32'h5A5A_5A5A; be_buf[0] = 4'h0;
        burst(32'h0000_010C, WR, 1, 0);
        idle(1);
        burst(32'h0000_010C, RD, 1, 0);
        check("post_rst_data", rd_buf[0], 32'h5A5A_5A5A);
        check("post_rst_count", {24'd0, xfer_count}, 32'd10);
        idle(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/pci_target_mem.md
PCI_TARGET_MEM -- requirements
Module: pci_target_mem

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h0000_0100, meaning the decode base; bits [4:0] are ignored.
REQ-002 The block SHALL have parameter WAIT_STATES, default 1, range 0-7, meaning initial TRDY# wait cycles after DEVSEL# assertion.
REQ-003 The block SHALL have parameter READ_CMD, default 4'b0110, meaning the memory-read C_BE code.
REQ-004 The block SHALL have parameter WRITE_CMD, default 4'b0111, meaning the memory-write C_BE code.
REQ-005 Ports SHALL be:
clk  in  1  bus clock, all sampling on rising edge
rst  in  1  asynchronous, active-high reset
AD  inout  32  multiplexed address/data bus
C_BE  in  4  command in address phase, active-low byte enables in data phase
FRAME  in  1  active-low, master framing
IRDY  in  1  active-low, master ready
DEVSEL  inout  1  active-low, driven 0/1 or Z
TRDY  inout  1  active-low, driven 0/1 or Z
xfer_done  out  1  one-cycle pulse per completed data phase
xfer_count  out  8  data phases completed since reset, wraps 255->0

Function
REQ-006 Storage SHALL be 8 x 32-bit words indexed by a 3-bit index.
REQ-007 FSM states SHALL be IDLE, DECODE, WAIT, DATA, TURN.
REQ-008 IDLE: an address phase is an edge with FRAME=0 and registered previous FRAME=1; it is a hit if AD[31:5]==BASE_ADDR[31:5] and C_BE is READ_CMD or WRITE_CMD.
REQ-009 On hit: latch index=AD[4:2] and the command, then go to DECODE; misses and other commands stay in IDLE with all outputs Z.
REQ-010 DECODE: DEVSEL=0, TRDY=1; load the wait counter with WAIT_STATES; next state is WAIT if WAIT_STATES>0, else DATA.
REQ-011 WAIT: DEVSEL=0, TRDY=1; decrement the counter and enter DATA when it reaches 0.
REQ-012 DATA: DEVSEL=0, TRDY=0.
REQ-013 A data phase completes on an edge sampling IRDY=0 and TRDY=0; the FSM SHALL never insert target waits after the first data phase.
REQ-014 On a write completion: for each i with C_BE[i]=0, store AD[8i+7:8i] into mem[index]; bytes with C_BE[i]=1 are unchanged.
REQ-015 On a read: AD SHALL be driven with mem[index] in WAIT and DATA (DECODE is turnaround, AD=Z), and updated the cycle after each completion.
REQ-016 Index SHALL increment by 1 per completion, wrapping 7->0 (linear burst).
REQ-017 A completion with FRAME=1 is the last phase: go to TURN.
REQ-018 Master abandon: FRAME=1 and IRDY=1 sampled in WAIT or DATA SHALL go to TURN with no transfer.
REQ-019 TURN: drive DEVSEL=1 and TRDY=1 for one cycle, release AD, then return to IDLE with DEVSEL/TRDY Z.
REQ-020 xfer_done SHALL pulse on the cycle after each completion, and xfer_count SHALL increment at the same time.
REQ-021 A new address phase SHALL be ignored unless the FSM is in IDLE.
REQ-022 Outside DECODE..TURN, AD, DEVSEL and TRDY SHALL be Z.

Reset
REQ-023 On rst=1, immediately (asynchronously): state=IDLE; AD, DEVSEL and TRDY Z; xfer_done=0; xfer_count=0; wait counter=0; prevFRAME=1.
REQ-024 Memory contents SHALL be cleared to 0 on reset.
REQ-025 Reset asserted mid-burst SHALL abort the burst with no further memory writes; on release, the FSM waits for a fresh address phase.

Verification
REQ-026 Single write: AD=0x104, C_BE=0111, then data 0xDEADBEEF with C_BE=0000, IRDY=0, FRAME=1 -> DEVSEL low 1 cycle after the address phase, TRDY low 2 cycles after it, mem[1]=0xDEADBEEF, xfer_count=1.
REQ-027 Burst write of 3 words from AD=0x11C -> mem[7], mem[0], mem[1] written (index wraps); xfer_count=3; TURN drives DEVSEL/TRDY high for 1 cycle, then Z.
REQ-028 Byte-enable write: C_BE=1010 with data 0x11223344 over mem[2]=0 -> mem[2]=0x00220044.
REQ-029 Read after REQ-026: AD=0x104, C_BE=0110 -> AD=Z during DECODE; AD=0xDEADBEEF from WAIT on; completion when IRDY=0.
REQ-030 Miss: AD=0x200 -> DEVSEL, TRDY and AD stay Z, and xfer_count is unchanged.
REQ-031 Robustness: rst pulse mid-burst after 1 of 4 words -> outputs Z immediately, mem all 0, xfer_count=0; the next hit transaction completes normally.
